fir_audio_i2s_tx: RTL

FIR_AUDIO_I2S_TX -- requirements
Module: fir_audio_i2s_tx

---
 rtl/fir_audio_pkg.sv | 34 +++
 rtl/fir_audio_i2s_tx_if.sv | 28 ++
 rtl/audio_sample_fifo.sv | 52 +++++
 rtl/fir_audio_i2s_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fir_audio_pkg.sv
// Shared widths, frame geometry and the FIR-to-sample conversion used by the
// audio I2S transmitter.
package fir_audio_pkg;

  localparam int FIR_DOUT_W      = 36;
  localparam int SAMPLE_W        = 16;
  localparam int SLOTS_PER_FRAME = 64;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

  localparam int LEFT_FIRST_SLOT  = 1;
  localparam int LEFT_LAST_SLOT   = 16;
  localparam int RIGHT_START_SLOT = 32;
  localparam int RIGHT_FIRST_SLOT = 33;
  localparam int RIGHT_LAST_SLOT  = 48;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  // Round half up at bit 'shift', then clamp into the signed 16-bit range.
  function automatic logic [SAMPLE_W-1:0] round_sat(input logic [FIR_DOUT_W-1:0] d,
                                                    input int shift);
    logic signed [FIR_DOUT_W:0] sum;
    logic signed [FIR_DOUT_W:0] r;
    sum = {d[FIR_DOUT_W-1], d} + ((FIR_DOUT_W + 1)'(1) << (shift - 1));
    r   = sum >>> shift;
    if (r > (FIR_DOUT_W + 1)'(SAT_MAX)) begin
      return SAMPLE_W'(SAT_MAX);
    end else if (r < (FIR_DOUT_W + 1)'(SAT_MIN)) begin
      return SAMPLE_W'(SAT_MIN);
    end
    return r[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fir_audio_i2s_tx_if.sv
// Sample input strobe/data plus I2S and status outputs of the transmitter.
interface fir_audio_i2s_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  import fir_audio_pkg::*;

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  rdy;
  logic [FIR_DOUT_W-1:0] dout;
  logic                  bclk;
  logic                  lrck;
  logic                  sdata;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  overflow;
  logic                  underrun;

  modport master (
    output rdy, dout,
    input  bclk, lrck, sdata, fifo_level, overflow, underrun
  );

  modport slave (
    input  rdy, dout,
    output bclk, lrck, sdata, fifo_level, overflow, underrun
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Single-clock sample FIFO; a push into a full FIFO is taken only when a pop
// frees an entry on the same edge.
module audio_sample_fifo
  import fir_audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [SAMPLE_W-1:0]     wr_data_i,
  output logic [SAMPLE_W-1:0]     rd_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0]  level_q;
  logic                wr_en, rd_en;

  assign full_o    = (level_q == LEVEL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign rd_en     = pop_i & ~empty_o;
  assign wr_en     = push_i & (~full_o | rd_en);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // NOTE: the storage array has no reset; clearing the pointers and level is what discards its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LEVEL_W'(wr_en) - LEVEL_W'(rd_en);
    end
  end

endmodule

// File: rtl/fir_audio_i2s_tx.sv
// FIR output to mono I2S transmitter: round/saturate to 16 bits, buffer in a
// FIFO, and shift each sample out on both channels of a 64-slot frame.
module fir_audio_i2s_tx
  import fir_audio_pkg::*;
#(
  parameter int SHIFT      = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 2
) (
  input logic               clk,
  input logic               sclr,
  fir_audio_i2s_tx_if.slave bus
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W   = $clog2(BCLK_DIV + 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic                lrck_q, lrck_d;
  logic                sdata_q, sdata_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                overflow_q, overflow_d;
  logic                underrun_q, underrun_d;

  logic                tick, slot_start, frame_start, in_data_slot;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_rd_data;
  logic [LEVEL_W-1:0]  fifo_level;

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .sclr      (sclr),
    .push_i    (pend_valid_q),
    .pop_i     (fifo_pop),
    .wr_data_i (pend_q),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no branch can infer a latch.
    div_d        = div_q + DIV_W'(1);
    bclk_d       = bclk_q;
    lrck_d       = lrck_q;
    sdata_d      = sdata_q;
    slot_d       = slot_q;
    shift_d      = shift_q;
    underrun_d   = underrun_q;
    in_data_slot = 1'b0;

    tick        = (div_q == DIV_W'(BCLK_DIV - 1));
    slot_start  = tick & bclk_q;
    frame_start = slot_start && (slot_q == SLOT_W'(SLOTS_PER_FRAME - 1));
    fifo_pop    = frame_start & ~fifo_empty;

    if (tick) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end

    // A slot begins on each bclk falling edge; slot counter wraps 63 -> 0.
    if (slot_start) begin
      slot_d       = slot_q + SLOT_W'(1);
      lrck_d       = (slot_d >= SLOT_W'(RIGHT_START_SLOT));
      in_data_slot = (slot_d >= SLOT_W'(LEFT_FIRST_SLOT)  && slot_d <= SLOT_W'(LEFT_LAST_SLOT)) ||
                     (slot_d >= SLOT_W'(RIGHT_FIRST_SLOT) && slot_d <= SLOT_W'(RIGHT_LAST_SLOT));
      sdata_d      = 1'b0;
      if (frame_start) begin
        shift_d    = fifo_empty ? '0 : fifo_rd_data;
        underrun_d = underrun_q | fifo_empty;
      end else if (in_data_slot) begin
        // Rotate so the word is intact again for the right channel.
        sdata_d = shift_q[SAMPLE_W-1];
        shift_d = {shift_q[SAMPLE_W-2:0], shift_q[SAMPLE_W-1]};
      end
    end

    overflow_d   = overflow_q | (pend_valid_q & fifo_full & ~fifo_pop);
    pend_valid_d = bus.rdy;
    pend_d       = bus.rdy ? round_sat(bus.dout, SHIFT) : pend_q;
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (sclr) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b1;
      sdata_q      <= 1'b0;
      slot_q       <= SLOT_W'(SLOTS_PER_FRAME - 1);
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      slot_q       <= slot_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.bclk       = bclk_q;
  assign bus.lrck       = lrck_q;
  assign bus.sdata      = sdata_q;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = overflow_q;
  assign bus.underrun   = underrun_q;

endmodule
